// File: rtl/spi_transmitter_fifo.sv
// SPI slave transmitter: a word FIFO feeds a byte-serialising FSM. Each byte can
// be skipped through a valid mask, and the bit order is chosen per byte.
module spi_transmitter_fifo #(
  parameter int NBYTES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter logic [8*NBYTES-1:0] ID_WORD = (8*NBYTES)'(32'h534c4131)
) (
  input  logic                clock,
  input  logic                extReset,
  input  logic                sclk,
  input  logic                cs,
  input  logic                send,
  input  logic [8*NBYTES-1:0] send_data,
  input  logic [NBYTES-1:0]   send_valid,
  input  logic                write_meta,
  input  logic [7:0]          meta_data,
  input  logic                query_id,
  input  logic                query_dataIn,
  input  logic [8*NBYTES-1:0] dataIn,
  input  logic                msb_first,
  output logic                tx,
  output logic                busy,
  output logic                byteDone,
  output logic                full,
  output logic                overflow
);

  localparam int W = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);
  localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(FIFO_DEPTH);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_POLL = 2'd3;

  logic [W-1:0]      fifo_data  [FIFO_DEPTH];
  logic [NBYTES-1:0] fifo_valid [FIFO_DEPTH];
  logic [PTRW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0]   count, count_next;
  logic              fifo_empty, push, pop;

  logic [1:0]        state;
  logic [W-1:0]      word;
  logic [NBYTES-1:0] mask;
  logic [IDXW-1:0]   byte_idx;
  logic [7:0]        tx_buffer;
  logic [7:0]        cur_byte;
  logic [2:0]        bits;
  logic [2:0]        bit_sel;
  logic              msb_cur;
  logic              byte_done;
  logic              dly_sclk;
  logic              falling;

  assign fifo_empty = (count == '0);
  assign push       = send && !full;
  assign pop        = (state == ST_IDLE) && !fifo_empty;
  assign falling    = dly_sclk && !sclk;
  assign cur_byte   = word[{byte_idx, 3'b000} +: 8];
  assign bit_sel    = msb_cur ? (3'd7 - bits) : bits;
  assign byteDone   = byte_done;

  always_comb begin
    count_next = count;
    if (push && !pop) count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr]  <= send_data;
      fifo_valid[wr_ptr] <= send_valid;
    end
  end

  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      full     <= (count_next == DEPTH_CNT);
      overflow <= send && full;
    end
  end

  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      state     <= ST_INIT;
      word      <= '0;
      mask      <= '0;
      byte_idx  <= '0;
      tx_buffer <= 8'hFF;
      bits      <= 3'd0;
      msb_cur   <= 1'b1;
      byte_done <= 1'b1;
      dly_sclk  <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      dly_sclk <= sclk;

      // Bit engine first; any byte load below overrides it in the same cycle.
      if (cs) begin
        bits <= 3'd0;
      end else if (falling && !byte_done) begin
        bits <= bits + 3'd1;
        if (bits == 3'd7) byte_done <= 1'b1;
      end

      case (state)
        ST_INIT: begin
          byte_done <= 1'b1;
          tx_buffer <= 8'hFF;
          byte_idx  <= '0;
          state     <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!fifo_empty) begin
            word     <= fifo_data[rd_ptr];
            mask     <= fifo_valid[rd_ptr];
            byte_idx <= '0;
            state    <= ST_SEND;
          end else if (query_id) begin
            word     <= ID_WORD;
            mask     <= '1;
            byte_idx <= '0;
            state    <= ST_SEND;
          end else if (query_dataIn) begin
            word     <= dataIn;
            mask     <= '1;
            byte_idx <= '0;
            state    <= ST_SEND;
          end else if (write_meta) begin
            tx_buffer <= meta_data;
            byte_done <= 1'b0;
            bits      <= 3'd0;
            msb_cur   <= msb_first;
          end
        end
        ST_SEND: begin
          tx_buffer <= cur_byte;
          byte_done <= !mask[byte_idx];
          bits      <= 3'd0;
          msb_cur   <= msb_first;
          byte_idx  <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
          state     <= ST_POLL;
        end
        ST_POLL: begin
          if (byte_done) state <= (byte_idx == '0) ? ST_IDLE : ST_SEND;
        end
        default: state <= ST_INIT;
      endcase

      tx   <= (cs || byte_done) ? 1'b1 : tx_buffer[bit_sel];
      busy <= (state != ST_IDLE) || !fifo_empty || send || !byte_done;
    end
  end

endmodule

// File: tb/tb_spi_transmitter_fifo.sv
// Bench for spi_transmitter_fifo: a host model clocks bytes out over SPI and a
// scoreboard compares each received byte against the queue of expected bytes.
module tb_spi_transmitter_fifo;

  localparam int NB = 4;
  localparam int W  = 32;

  logic          clock = 1'b0;
  logic          extReset;
  logic          sclk;
  logic          cs;
  logic          send;
  logic [W-1:0]  send_data;
  logic [NB-1:0] send_valid;
  logic          write_meta;
  logic [7:0]    meta_data;
  logic          query_id;
  logic          query_dataIn;
  logic [W-1:0]  dataIn;
  logic          msb_first;
  logic          tx;
  logic          busy;
  logic          byteDone;
  logic          full;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  spi_transmitter_fifo dut (
    .clock(clock), .extReset(extReset), .sclk(sclk), .cs(cs),
    .send(send), .send_data(send_data), .send_valid(send_valid),
    .write_meta(write_meta), .meta_data(meta_data),
    .query_id(query_id), .query_dataIn(query_dataIn), .dataIn(dataIn),
    .msb_first(msb_first), .tx(tx), .busy(busy), .byteDone(byteDone),
    .full(full), .overflow(overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_word(input logic [W-1:0] w, input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++)
      if (v[i]) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic do_send(input logic [W-1:0] w, input logic [NB-1:0] v);
    send = 1'b1; send_data = w; send_valid = v;
    tick();
    send = 1'b0;
    expect_word(w, v);
  endtask

  task automatic wait_load(output bit ok);
    int n = 0;
    while (byteDone !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    ok = (byteDone === 1'b0);
  endtask

  // Host: sclk high, sample tx, then falling edge; three clocks per phase.
  task automatic host_bits(input int n, input logic msb, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      repeat (3) tick();
      if (msb) b[7-i] = tx; else b[i] = tx;
      sclk = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic recv_byte(input string name);
    bit ok;
    logic [7:0] got, exp;
    wait_load(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no byte load seen (byteDone stuck at %b)", name, byteDone);
    end else begin
      host_bits(8, msb_first, got);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s: got byte %h, expected no byte", name, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL %s: got byte %h, expected %h", name, got, exp);
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || byteDone !== 1'b1 || tx !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: busy=%b byteDone=%b tx=%b pending=%0d, expected 0 1 1 0",
               name, busy, byteDone, tx, exp_q.size());
    end
  endtask

  task automatic test_reset();
    extReset = 1'b1; sclk = 1'b0; cs = 1'b1; send = 1'b0; send_data = '0;
    send_valid = '0; write_meta = 1'b0; meta_data = 8'h00; query_id = 1'b0;
    query_dataIn = 1'b0; dataIn = '0; msb_first = 1'b1;
    repeat (3) tick();
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (byteDone !== 1'b1) begin errors++; $display("FAIL reset_byteDone: got %b expected 1", byteDone); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    extReset = 1'b0;
    repeat (3) tick();
    cs = 1'b0;
    tick();
    wait_idle("reset_settle");
  endtask

  task automatic test_msb_first();
    msb_first = 1'b1;
    do_send(32'hA1B2C3D4, 4'hF);
    recv_byte("msb_b0");
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL msb_busy_mid: got %b expected 1", busy); end
    recv_byte("msb_b1");
    recv_byte("msb_b2");
    recv_byte("msb_b3");
    // host_bits returns three clocks after the last falling edge: byteDone plus two.
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL msb_busy_end: got %b expected 0", busy); end
    wait_idle("msb_idle");
  endtask

  task automatic test_lsb_first();
    msb_first = 1'b0;
    do_send(32'hA1B2C3D4, 4'hF);
    for (int i = 0; i < NB; i++) recv_byte("lsb_byte");
    wait_idle("lsb_idle");
    msb_first = 1'b1;
  endtask

  task automatic test_masked();
    do_send(32'hA1B2C3D4, 4'b0101);
    recv_byte("mask_b0");
    recv_byte("mask_b2");
    wait_idle("mask_idle");
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [W-1:0] w;
    cs = 1'b1;
    do_send(32'h0BADF00D, 4'hF);
    wait_load(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_preload: byteDone=%b expected 0", byteDone); end
    for (int k = 0; k < 5; k++) begin
      w = 32'h10203040 + 32'(k) * 32'h01010101;
      send = 1'b1; send_data = w; send_valid = 4'hF;
      tick();
      if (k < 4) expect_word(w, 4'hF);
      if (k == 2) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL b2b_full3: got %b expected 0", full); end
      end
      if (k == 3) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL b2b_full4: got %b expected 1", full); end
      end
      if (k == 4) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf: got %b expected 1", overflow); end
      end
    end
    send = 1'b0;
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf_pulse: got %b expected 0", overflow); end
    cs = 1'b0;
    for (int i = 0; i < 20; i++) recv_byte("b2b_drain");
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL b2b_full_end: got %b expected 0", full); end
    wait_idle("b2b_idle");
  endtask

  task automatic test_query();
    send = 1'b1; send_data = 32'h11223344; send_valid = 4'hF; query_id = 1'b1;
    tick();
    send = 1'b0; query_id = 1'b0;
    exp_q.push_back(8'h31); exp_q.push_back(8'h41);
    exp_q.push_back(8'h4C); exp_q.push_back(8'h53);
    expect_word(32'h11223344, 4'hF);
    recv_byte("qid_b0");
    dataIn = 32'hDEADBEEF; query_dataIn = 1'b1;
    tick();
    query_dataIn = 1'b0;
    for (int i = 0; i < 7; i++) recv_byte("qid_then_send");
    wait_idle("qid_idle");
    dataIn = 32'hCAFEF00D; query_dataIn = 1'b1;
    tick();
    query_dataIn = 1'b0;
    expect_word(32'hCAFEF00D, 4'hF);
    for (int i = 0; i < NB; i++) recv_byte("qdata");
    wait_idle("qdata_idle");
  endtask

  task automatic test_meta();
    meta_data = 8'h5A; write_meta = 1'b1;
    tick();
    write_meta = 1'b0;
    exp_q.push_back(8'h5A);
    recv_byte("meta");
    wait_idle("meta_idle");
  endtask

  task automatic test_reset_mid_byte();
    bit ok;
    logic [7:0] part;
    do_send(32'h55AA33CC, 4'hF);
    wait_load(ok);
    host_bits(3, 1'b1, part);
    for (int k = 0; k < 4; k++) begin
      send = 1'b1; send_data = 32'(k); send_valid = 4'hF;
      tick();
    end
    send = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL mid_full_before: got %b expected 1", full); end
    #2 extReset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL mid_tx: got %b expected 1", tx); end
    checks++; if (byteDone !== 1'b1) begin errors++; $display("FAIL mid_byteDone: got %b expected 1", byteDone); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL mid_full: got %b expected 0", full); end
    tick();
    extReset = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    do_send(32'h0F1E2D3C, 4'hF);
    for (int i = 0; i < NB; i++) recv_byte("mid_restart");
    wait_idle("mid_idle");
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_masked();
    test_back_to_back();
    test_query();
    test_meta();
    test_reset_mid_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
